// File: rtl/enemy_pkg.sv
// Shared encodings for the enemy movement unit.
//   mode_e  : movement mode selected by the game logic
//   face_e  : sprite facing direction reported to the renderer
//   state_e : life-cycle state of one enemy
package enemy_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'b00,
    MODE_PATROL_H = 2'b01,
    MODE_PATROL_V = 2'b10,
    MODE_CHASE    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    FACE_UP    = 2'b00,
    FACE_DOWN  = 2'b01,
    FACE_LEFT  = 2'b10,
    FACE_RIGHT = 2'b11
  } face_e;

  typedef enum logic [1:0] {
    ST_ALIVE = 2'b00,
    ST_DYING = 2'b01,
    ST_DEAD  = 2'b10
  } state_e;

endpackage

// File: rtl/enemy_step_calc.sv
// Combinational move calculator: given the current position, player position,
// patrol direction flags and mode, produces the position, facing and direction
// flags that a move event would load. Holds no state.
//   mode_i              movement mode
//   hpos_i / vpos_i     current enemy position
//   player_h_i/_v_i     player position (chase target)
//   dir_h_i / dir_v_i   patrol directions (1 = right / down)
//   facing_i            current facing, kept when nothing moves
//   hpos_o / vpos_o     position after the move
//   facing_o            facing after the move
//   dir_h_o / dir_v_o   patrol directions after the move
module enemy_step_calc
  import enemy_pkg::*;
#(
  parameter int POS_W = 10,
  parameter int STEP  = 5,
  parameter int H_MIN = 8,
  parameter int H_MAX = 623,
  parameter int V_MIN = 8,
  parameter int V_MAX = 463
) (
  input  mode_e              mode_i,
  input  logic [POS_W-1:0]   hpos_i,
  input  logic [POS_W-1:0]   vpos_i,
  input  logic [POS_W-1:0]   player_h_i,
  input  logic [POS_W-1:0]   player_v_i,
  input  logic               dir_h_i,
  input  logic               dir_v_i,
  input  face_e              facing_i,
  output logic [POS_W-1:0]   hpos_o,
  output logic [POS_W-1:0]   vpos_o,
  output face_e              facing_o,
  output logic               dir_h_o,
  output logic               dir_v_o
);

  // One extra bit of headroom so sums and differences never wrap.
  localparam int AW = POS_W + 1;
  localparam logic [AW-1:0] STEP_W  = AW'(STEP);
  localparam logic [AW-1:0] H_MIN_W = AW'(H_MIN);
  localparam logic [AW-1:0] H_MAX_W = AW'(H_MAX);
  localparam logic [AW-1:0] V_MIN_W = AW'(V_MIN);
  localparam logic [AW-1:0] V_MAX_W = AW'(V_MAX);

  // Bound a widened coordinate to one axis of the play field.
  function automatic logic [POS_W-1:0] clamp(input logic [AW-1:0] x,
                                              input logic [AW-1:0] lo,
                                              input logic [AW-1:0] hi);
    logic [AW-1:0] r;
    if (x < lo) begin
      r = lo;
    end else if (x > hi) begin
      r = hi;
    end else begin
      r = x;
    end
    return r[POS_W-1:0];
  endfunction

  logic [AW-1:0] h_w, v_w, ph_w, pv_w;
  logic [AW-1:0] dx_w, dy_w, adx_w, ady_w, sh_w, sv_w;
  logic [AW-1:0] res_h_w, res_v_w;

  // Next position/facing/direction for the selected mode.
  always_comb begin
    h_w      = {1'b0, hpos_i};
    v_w      = {1'b0, vpos_i};
    ph_w     = {1'b0, player_h_i};
    pv_w     = {1'b0, player_v_i};
    // Two's-complement differences; MSB set means the player is left/above.
    dx_w     = ph_w - h_w;
    dy_w     = pv_w - v_w;
    adx_w    = dx_w[AW-1] ? (-dx_w) : dx_w;
    ady_w    = dy_w[AW-1] ? (-dy_w) : dy_w;
    sh_w     = (adx_w < STEP_W) ? adx_w : STEP_W;
    sv_w     = (ady_w < STEP_W) ? ady_w : STEP_W;
    res_h_w  = h_w;
    res_v_w  = v_w;
    facing_o = facing_i;
    dir_h_o  = dir_h_i;
    dir_v_o  = dir_v_i;
    case (mode_i)
      MODE_PATROL_H: begin
        if (dir_h_i) begin
          if (h_w + STEP_W >= H_MAX_W) begin
            res_h_w = H_MAX_W;
            dir_h_o = 1'b0;
          end else begin
            res_h_w = h_w + STEP_W;
          end
        end else begin
          if (h_w < H_MIN_W + STEP_W) begin
            res_h_w = H_MIN_W;
            dir_h_o = 1'b1;
          end else begin
            res_h_w = h_w - STEP_W;
          end
        end
        // Facing tracks the direction the enemy will travel next.
        facing_o = dir_h_o ? FACE_RIGHT : FACE_LEFT;
      end
      MODE_PATROL_V: begin
        if (dir_v_i) begin
          if (v_w + STEP_W >= V_MAX_W) begin
            res_v_w = V_MAX_W;
            dir_v_o = 1'b0;
          end else begin
            res_v_w = v_w + STEP_W;
          end
        end else begin
          if (v_w < V_MIN_W + STEP_W) begin
            res_v_w = V_MIN_W;
            dir_v_o = 1'b1;
          end else begin
            res_v_w = v_w - STEP_W;
          end
        end
        facing_o = dir_v_o ? FACE_DOWN : FACE_UP;
      end
      MODE_CHASE: begin
        // Horizontal wins ties; the step shrinks to snap onto the target.
        if ((adx_w >= ady_w) && (adx_w != {AW{1'b0}})) begin
          res_h_w  = dx_w[AW-1] ? (h_w - sh_w) : (h_w + sh_w);
          facing_o = dx_w[AW-1] ? FACE_LEFT : FACE_RIGHT;
        end else if (ady_w != {AW{1'b0}}) begin
          res_v_w  = dy_w[AW-1] ? (v_w - sv_w) : (v_w + sv_w);
          facing_o = dy_w[AW-1] ? FACE_UP : FACE_DOWN;
        end else begin
          facing_o = facing_i;
        end
      end
      default: begin
        facing_o = facing_i;
      end
    endcase
    // Patrol results already lie inside the box when starting inside it;
    // chase results may not, so every result is bounded here.
    hpos_o = clamp(res_h_w, H_MIN_W, H_MAX_W);
    vpos_o = clamp(res_v_w, V_MIN_W, V_MAX_W);
  end

endmodule

// File: rtl/enemy_patrol.sv
// One enemy: position register, move-rate divider, life-cycle FSM
// (ALIVE -> DYING -> DEAD -> ALIVE) and registered sprite outputs.
//   clk, rst_n   clock, synchronous active-low reset
//   frame_tick   one-cycle pulse per video frame
//   enable       movement enable (0 freezes like HOLD)
//   mode         00 hold, 01 patrol H, 10 patrol V, 11 chase
//   player_pos   {player_h, player_v} chase target
//   hit, respawn one-cycle life-cycle requests
//   position     {hpos, vpos}
//   facing       00 up, 01 down, 10 left, 11 right
//   moving       1 for the cycle after a position change
//   alive        1 while in ALIVE
module enemy_patrol
  import enemy_pkg::*;
#(
  parameter int POS_W        = 10,
  parameter int INIT_H       = 263,
  parameter int INIT_V       = 170,
  parameter int STEP         = 5,
  parameter int H_MIN        = 8,
  parameter int H_MAX        = 623,
  parameter int V_MIN        = 8,
  parameter int V_MAX        = 463,
  parameter int MOVE_DIV     = 2,
  parameter int DEATH_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [2*POS_W-1:0] player_pos,
  input  logic               hit,
  input  logic               respawn,
  output logic [2*POS_W-1:0] position,
  output logic [1:0]         facing,
  output logic               moving,
  output logic               alive
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int DTH_W = $clog2(DEATH_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MOVE_DIV - 1);
  localparam logic [POS_W-1:0] INIT_H_P = POS_W'(INIT_H);
  localparam logic [POS_W-1:0] INIT_V_P = POS_W'(INIT_V);

  state_e           state_q, state_d;
  logic [POS_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
  face_e            face_q, face_d;
  logic             moving_q, moving_d, alive_q, alive_d;
  logic             dir_h_q, dir_h_d, dir_v_q, dir_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DTH_W-1:0] death_q, death_d;

  logic             cnt_run, move_evt;
  logic [POS_W-1:0] calc_h, calc_v;
  face_e            calc_face;
  logic             calc_dir_h, calc_dir_v;

  enemy_step_calc #(
    .POS_W (POS_W), .STEP (STEP),
    .H_MIN (H_MIN), .H_MAX (H_MAX),
    .V_MIN (V_MIN), .V_MAX (V_MAX)
  ) u_step (
    .mode_i     (mode_e'(mode)),
    .hpos_i     (hpos_q),
    .vpos_i     (vpos_q),
    .player_h_i (player_pos[2*POS_W-1:POS_W]),
    .player_v_i (player_pos[POS_W-1:0]),
    .dir_h_i    (dir_h_q),
    .dir_v_i    (dir_v_q),
    .facing_i   (face_q),
    .hpos_o     (calc_h),
    .vpos_o     (calc_v),
    .facing_o   (calc_face),
    .dir_h_o    (calc_dir_h),
    .dir_v_o    (calc_dir_v)
  );

  // Next-state logic: move divider, life-cycle FSM and position update.
  always_comb begin
    state_d = state_q;
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    face_d  = face_q;
    dir_h_d = dir_h_q;
    dir_v_d = dir_v_q;
    death_d = death_q;

    cnt_run  = (state_q == ST_ALIVE) && enable && (mode_e'(mode) != MODE_HOLD);
    move_evt = cnt_run && frame_tick && (cnt_q == LAST_CNT);
    if (!cnt_run) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (frame_tick) begin
      cnt_d = move_evt ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_ALIVE: begin
        // A hit on a move-event cycle suppresses the move.
        if (hit) begin
          state_d = ST_DYING;
          death_d = DTH_W'(DEATH_FRAMES);
        end else if (move_evt) begin
          hpos_d  = calc_h;
          vpos_d  = calc_v;
          face_d  = calc_face;
          dir_h_d = calc_dir_h;
          dir_v_d = calc_dir_v;
        end else begin
          state_d = ST_ALIVE;
        end
      end
      ST_DYING: begin
        if (frame_tick) begin
          death_d = death_q - DTH_W'(1);
          if (death_q == DTH_W'(1)) begin
            state_d = ST_DEAD;
          end else begin
            state_d = ST_DYING;
          end
        end else begin
          state_d = ST_DYING;
        end
      end
      ST_DEAD: begin
        if (respawn) begin
          state_d = ST_ALIVE;
          hpos_d  = INIT_H_P;
          vpos_d  = INIT_V_P;
          face_d  = FACE_DOWN;
          dir_h_d = 1'b1;
          dir_v_d = 1'b1;
        end else begin
          state_d = ST_DEAD;
        end
      end
      default: begin
        state_d = ST_ALIVE;
      end
    endcase

    moving_d = ({hpos_d, vpos_d} != {hpos_q, vpos_q});
    alive_d  = (state_d == ST_ALIVE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_ALIVE;
      hpos_q   <= INIT_H_P;
      vpos_q   <= INIT_V_P;
      face_q   <= FACE_DOWN;
      moving_q <= 1'b0;
      alive_q  <= 1'b1;
      dir_h_q  <= 1'b1;
      dir_v_q  <= 1'b1;
      cnt_q    <= {CNT_W{1'b0}};
      death_q  <= {DTH_W{1'b0}};
    end else begin
      state_q  <= state_d;
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      face_q   <= face_d;
      moving_q <= moving_d;
      alive_q  <= alive_d;
      dir_h_q  <= dir_h_d;
      dir_v_q  <= dir_v_d;
      cnt_q    <= cnt_d;
      death_q  <= death_d;
    end
  end

  assign position = {hpos_q, vpos_q};
  assign facing   = face_q;
  assign moving   = moving_q;
  assign alive    = alive_q;

endmodule

// File: tb/tb_enemy_patrol.sv
module tb_enemy_patrol;

  localparam int POS_W = 10, INIT_H = 263, INIT_V = 170, STEP = 5;
  localparam int H_MIN = 8, H_MAX = 623, V_MIN = 8, V_MAX = 463;
  localparam int MOVE_DIV = 2, DEATH_FRAMES = 30, H_MAX_B = 270;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, frame_tick, enable, hit, respawn;
  logic [1:0]         mode;
  logic [2*POS_W-1:0] player_pos;
  logic [2*POS_W-1:0] pos_a, pos_b;
  logic [1:0]         face_a, face_b;
  logic               mov_a, mov_b, alive_a, alive_b;

  enemy_patrol #(.POS_W(POS_W), .INIT_H(INIT_H), .INIT_V(INIT_V), .STEP(STEP),
                 .H_MIN(H_MIN), .H_MAX(H_MAX), .V_MIN(V_MIN), .V_MAX(V_MAX),
                 .MOVE_DIV(MOVE_DIV), .DEATH_FRAMES(DEATH_FRAMES)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .mode(mode), .player_pos(player_pos), .hit(hit), .respawn(respawn),
    .position(pos_a), .facing(face_a), .moving(mov_a), .alive(alive_a));

  // Second instance with a narrow right edge to exercise the bounce/clamp.
  enemy_patrol #(.POS_W(POS_W), .INIT_H(INIT_H), .INIT_V(INIT_V), .STEP(STEP),
                 .H_MIN(H_MIN), .H_MAX(H_MAX_B), .V_MIN(V_MIN), .V_MAX(V_MAX),
                 .MOVE_DIV(MOVE_DIV), .DEATH_FRAMES(DEATH_FRAMES)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .mode(mode), .player_pos(player_pos), .hit(hit), .respawn(respawn),
    .position(pos_b), .facing(face_b), .moving(mov_b), .alive(alive_b));

  // life: 0 alive, 1 dying, 2 dead
  typedef struct {
    int h; int v; int face; int moving; int alive;
    int life; int cnt; int death; int dirh; int dirv;
  } mdl_t;

  mdl_t ma, mb;
  int   vectors = 0;
  int   miscompares = 0;
  bit   model_ok = 1'b0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.h = INIT_H; m.v = INIT_V; m.face = 1; m.moving = 0; m.alive = 1;
    m.life = 0; m.cnt = 0; m.death = 0; m.dirh = 1; m.dirv = 1;
    return m;
  endfunction

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int clampi(int x, int lo, int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  function automatic mdl_t mdl_move(mdl_t m, int hmax, int md, int ph, int pv);
    int dx, dy, s;
    dx = ph - m.h;
    dy = pv - m.v;
    case (md)
      1: begin
        if (m.dirh != 0) begin
          if (m.h + STEP >= hmax) begin m.h = hmax; m.dirh = 0; end
          else m.h = m.h + STEP;
        end else begin
          if (m.h < H_MIN + STEP) begin m.h = H_MIN; m.dirh = 1; end
          else m.h = m.h - STEP;
        end
        m.face = (m.dirh != 0) ? 3 : 2;
      end
      2: begin
        if (m.dirv != 0) begin
          if (m.v + STEP >= V_MAX) begin m.v = V_MAX; m.dirv = 0; end
          else m.v = m.v + STEP;
        end else begin
          if (m.v < V_MIN + STEP) begin m.v = V_MIN; m.dirv = 1; end
          else m.v = m.v - STEP;
        end
        m.face = (m.dirv != 0) ? 1 : 0;
      end
      3: begin
        if (iabs(dx) >= iabs(dy) && dx != 0) begin
          s = (iabs(dx) < STEP) ? iabs(dx) : STEP;
          m.h = clampi(m.h + ((dx > 0) ? s : -s), H_MIN, hmax);
          m.face = (dx > 0) ? 3 : 2;
        end else if (dy != 0) begin
          s = (iabs(dy) < STEP) ? iabs(dy) : STEP;
          m.v = clampi(m.v + ((dy > 0) ? s : -s), V_MIN, V_MAX);
          m.face = (dy > 0) ? 1 : 0;
        end
      end
      default: ;
    endcase
    return m;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int hmax, logic rstn, logic ft, logic en,
                                    logic [1:0] md, int ph, int pv, logic ht, logic rs);
    mdl_t n;
    bit   ev;
    if (!rstn) return mdl_reset();
    n  = m;
    ev = 1'b0;
    if (m.life == 0 && en && md != 2'b00) begin
      if (ft) begin
        ev    = (m.cnt == MOVE_DIV - 1);
        n.cnt = (m.cnt + 1) % MOVE_DIV;
      end
    end else begin
      n.cnt = 0;
    end
    case (m.life)
      0: if (ht) begin n.life = 1; n.death = DEATH_FRAMES; end
         else if (ev) n = mdl_move(n, hmax, int'(md), ph, pv);
      1: if (ft) begin n.death = n.death - 1; if (n.death == 0) n.life = 2; end
      2: if (rs) n = mdl_reset();
      default: ;
    endcase
    n.moving = (n.h != m.h || n.v != m.v) ? 1 : 0;
    n.alive  = (n.life == 0) ? 1 : 0;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    ma = mdl_next(ma, H_MAX, rst_n, frame_tick, enable, mode,
                  int'(player_pos[19:10]), int'(player_pos[9:0]), hit, respawn);
    mb = mdl_next(mb, H_MAX_B, rst_n, frame_tick, enable, mode,
                  int'(player_pos[19:10]), int'(player_pos[9:0]), hit, respawn);
    if (!rst_n) model_ok = 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("a.hpos", int'(pos_a[19:10]), ma.h);
      chk("a.vpos", int'(pos_a[9:0]), ma.v);
      chk("a.facing", int'(face_a), ma.face);
      chk("a.moving", int'(mov_a), ma.moving);
      chk("a.alive", int'(alive_a), ma.alive);
      chk("b.hpos", int'(pos_b[19:10]), mb.h);
      chk("b.vpos", int'(pos_b[9:0]), mb.v);
      chk("b.facing", int'(face_b), mb.face);
      chk("b.moving", int'(mov_b), mb.moving);
      chk("b.alive", int'(alive_b), mb.alive);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
    frame_tick = 1'b0;
    hit        = 1'b0;
    respawn    = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick();
      cyc();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; enable = 1'b0; mode = 2'b00;
    hit = 1'b0; respawn = 1'b0;
    player_pos = {10'd263, 10'd170};
    cyc();
    rst_n = 1'b1;
    chk("lit reset hpos", int'(pos_a[19:10]), 263);
    chk("lit reset vpos", int'(pos_a[9:0]), 170);
    chk("lit reset facing", int'(face_a), 1);
    chk("lit reset alive", int'(alive_a), 1);
    chk("lit reset moving", int'(mov_a), 0);

    // Horizontal patrol, plus bounce on the narrow instance.
    mode = 2'b01; enable = 1'b1;
    tick();
    chk("lit ph tick1 hpos", int'(pos_a[19:10]), 263);
    cyc();
    tick();
    chk("lit ph tick2 hpos", int'(pos_a[19:10]), 268);
    chk("lit ph tick2 moving", int'(mov_a), 1);
    chk("lit ph tick2 facing", int'(face_a), 3);
    cyc();
    chk("lit ph moving drop", int'(mov_a), 0);
    ticks(1);
    tick();
    chk("lit ph tick4 hpos", int'(pos_a[19:10]), 273);
    chk("lit bounce hpos", int'(pos_b[19:10]), 270);
    chk("lit bounce facing", int'(face_b), 2);
    cyc();
    ticks(2);
    chk("lit bounce back hpos", int'(pos_b[19:10]), 265);
    chk("lit ph tick6 hpos", int'(pos_a[19:10]), 278);

    // Disabled: frozen.
    enable = 1'b0;
    ticks(4);
    chk("lit freeze hpos", int'(pos_a[19:10]), 278);
    enable = 1'b1;

    // Chase to a target right of spawn, with snap and clamp.
    do_reset();
    mode = 2'b11; player_pos = {10'd300, 10'd170};
    ticks(16);
    chk("lit chase snap hpos", int'(pos_a[19:10]), 300);
    chk("lit chase clamp hpos", int'(pos_b[19:10]), 270);
    ticks(4);
    chk("lit chase rest hpos", int'(pos_a[19:10]), 300);
    chk("lit chase rest moving", int'(mov_a), 0);
    chk("lit chase clamp moving", int'(mov_b), 0);
    player_pos = {10'd300, 10'd100};
    ticks(2);
    chk("lit chase up vpos", int'(pos_a[9:0]), 165);
    chk("lit chase up facing", int'(face_a), 0);
    chk("lit chase b up vpos", int'(pos_b[9:0]), 165);

    // Life cycle: hit, ignored respawn while dying, death, respawn.
    hit = 1'b1;
    cyc();
    chk("lit hit alive", int'(alive_a), 0);
    respawn = 1'b1;
    cyc();
    chk("lit dying respawn ignored", int'(alive_a), 0);
    ticks(DEATH_FRAMES - 1);
    respawn = 1'b1;
    cyc();
    chk("lit last dying respawn ignored", int'(alive_a), 0);
    chk("lit frozen hpos", int'(pos_a[19:10]), 300);
    ticks(1);
    respawn = 1'b1;
    cyc();
    chk("lit respawn alive", int'(alive_a), 1);
    chk("lit respawn hpos", int'(pos_a[19:10]), 263);
    chk("lit respawn vpos", int'(pos_a[9:0]), 170);
    chk("lit respawn facing", int'(face_a), 1);

    // Reset during DYING, then hit colliding with a move event.
    hit = 1'b1;
    cyc();
    ticks(3);
    do_reset();
    chk("lit rst dying alive", int'(alive_a), 1);
    chk("lit rst dying hpos", int'(pos_a[19:10]), 263);
    mode = 2'b01;
    ticks(1);
    frame_tick = 1'b1; hit = 1'b1;
    cyc();
    chk("lit hit wins hpos", int'(pos_a[19:10]), 263);
    chk("lit hit wins alive", int'(alive_a), 0);

    // HOLD clears the move counter.
    do_reset();
    mode = 2'b01;
    ticks(1);
    mode = 2'b00;
    cyc();
    mode = 2'b01;
    ticks(1);
    chk("lit hold clears cnt", int'(pos_a[19:10]), 263);
    ticks(1);
    chk("lit after hold move", int'(pos_a[19:10]), 268);

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
